clue_stream_parser: RTL and testbench



---
 rtl/clue_stream_parser.sv | 211 +++++++++++++++++++++
 tb/tb_clue_stream_parser.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/clue_stream_parser.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | clue_stream_parser: decodes the board byte stream into BRAM clue words.      |
// | Rev 1.0 - initial parametrised release                                      |
// +----------------------------------------------------------------------------+
module clue_stream_parser #(
  parameter int MAX_DIM    = 64,
  parameter int MAX_CLUES  = 32,
  parameter int WORD_WIDTH = 16,
  parameter int ADDR_WIDTH = 12,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            byte_in,
  input  logic                  valid_in,
  output logic                  write_ready,
  output logic [ADDR_WIDTH-1:0] write_index,
  output logic [WORD_WIDTH-1:0] assignment,
  output logic                  board_done,
  output logic                  error,
  output logic                  busy,
  output logic [15:0]           n,
  output logic [15:0]           m
);

  typedef enum logic [2:0] {
    N_HI  = 3'd0,
    N_LO  = 3'd1,
    M_HI  = 3'd2,
    M_LO  = 3'd3,
    COUNT = 3'd4,
    CLUE  = 3'd5,
    ERROR = 3'd6
  } state_t;

  localparam logic [15:0]         C_MAX_DIM   = 16'(MAX_DIM);
  localparam logic [8:0]          C_MAX_CLUES = 9'(MAX_CLUES);
  localparam logic [ADDR_WIDTH:0] C_BASE      = (ADDR_WIDTH+1)'(BASE_ADDR);

  state_t                r_state, w_state_nxt;
  logic [7:0]            r_hi, w_hi_nxt;
  logic [15:0]           r_n_tmp, w_n_tmp_nxt;
  logic [15:0]           w_n_nxt, w_m_nxt;
  logic [15:0]           r_line, w_line_nxt;
  logic [7:0]            r_kleft, w_kleft_nxt;
  logic [16:0]           r_acc, w_acc_nxt;
  logic                  r_first, w_first_nxt;
  // One extra bit so a wrapped address is detectable before the write.
  logic [ADDR_WIDTH:0]   r_addr, w_addr_nxt;
  logic                  w_wr, w_done, w_err_nxt, w_busy_nxt;
  logic [ADDR_WIDTH-1:0] w_wr_idx;
  logic [WORD_WIDTH-1:0] w_wr_data;

  logic [15:0] w_m_val;
  logic [16:0] w_total;
  logic        w_last_line;
  logic [15:0] w_len;
  logic [16:0] w_acc_new;
  logic        w_ovf;

  assign w_m_val     = {r_hi, byte_in};
  assign w_total     = {1'b0, n} + {1'b0, m};
  assign w_last_line = (({1'b0, r_line} + 17'd1) == w_total);
  assign w_len       = (r_line < n) ? m : n;
  assign w_acc_new   = r_acc + 17'(byte_in) + (r_first ? 17'd0 : 17'd1);
  assign w_ovf       = r_addr[ADDR_WIDTH];

  always_comb begin
    w_state_nxt = r_state;
    w_hi_nxt    = r_hi;
    w_n_tmp_nxt = r_n_tmp;
    w_n_nxt     = n;
    w_m_nxt     = m;
    w_line_nxt  = r_line;
    w_kleft_nxt = r_kleft;
    w_acc_nxt   = r_acc;
    w_first_nxt = r_first;
    w_addr_nxt  = r_addr;
    w_wr        = 1'b0;
    w_wr_idx    = r_addr[ADDR_WIDTH-1:0];
    w_wr_data   = '0;
    w_done      = 1'b0;
    w_err_nxt   = error;
    w_busy_nxt  = busy;

    if (valid_in) begin
      case (r_state)
        N_HI: begin
          w_hi_nxt    = byte_in;
          w_busy_nxt  = 1'b1;
          w_state_nxt = N_LO;
        end
        N_LO: begin
          w_n_tmp_nxt = {r_hi, byte_in};
          w_state_nxt = M_HI;
        end
        M_HI: begin
          w_hi_nxt    = byte_in;
          w_state_nxt = M_LO;
        end
        M_LO: begin
          if (r_n_tmp == 16'd0 || r_n_tmp > C_MAX_DIM ||
              w_m_val == 16'd0 || w_m_val > C_MAX_DIM) begin
            w_state_nxt = ERROR;
          end else begin
            w_n_nxt     = r_n_tmp;
            w_m_nxt     = w_m_val;
            w_line_nxt  = 16'd0;
            w_addr_nxt  = C_BASE;
            w_state_nxt = COUNT;
          end
        end
        COUNT: begin
          if ({1'b0, byte_in} > C_MAX_CLUES || w_ovf) begin
            w_state_nxt = ERROR;
          end else begin
            w_wr       = 1'b1;
            w_wr_data  = {1'b1, (WORD_WIDTH-1)'(r_line)};
            w_addr_nxt = r_addr + 1'b1;
            w_kleft_nxt = byte_in;
            w_acc_nxt   = 17'd0;
            w_first_nxt = 1'b1;
            if (byte_in != 8'd0) begin
              w_state_nxt = CLUE;
            end else if (w_last_line) begin
              w_done      = 1'b1;
              w_busy_nxt  = 1'b0;
              w_addr_nxt  = C_BASE;
              w_state_nxt = N_HI;
            end else begin
              w_line_nxt = r_line + 16'd1;
            end
          end
        end
        CLUE: begin
          if (byte_in == 8'd0 || w_acc_new > {1'b0, w_len} || w_ovf) begin
            w_state_nxt = ERROR;
          end else begin
            w_wr        = 1'b1;
            w_wr_data   = {1'b0, (WORD_WIDTH-1)'(byte_in)};
            w_addr_nxt  = r_addr + 1'b1;
            w_acc_nxt   = w_acc_new;
            w_first_nxt = 1'b0;
            w_kleft_nxt = r_kleft - 8'd1;
            if (r_kleft == 8'd1) begin
              if (w_last_line) begin
                w_done      = 1'b1;
                w_busy_nxt  = 1'b0;
                w_addr_nxt  = C_BASE;
                w_state_nxt = N_HI;
              end else begin
                w_line_nxt  = r_line + 16'd1;
                w_state_nxt = COUNT;
              end
            end
          end
        end
        default: w_state_nxt = ERROR;
      endcase
    end

    // Entering ERROR from any state: flag it and drop busy in the same step.
    if (w_state_nxt == ERROR) begin
      w_err_nxt  = 1'b1;
      w_busy_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= N_HI;
      r_hi        <= '0;
      r_n_tmp     <= '0;
      n           <= '0;
      m           <= '0;
      r_line      <= '0;
      r_kleft     <= '0;
      r_acc       <= '0;
      r_first     <= 1'b0;
      r_addr      <= C_BASE;
      write_ready <= 1'b0;
      write_index <= '0;
      assignment  <= '0;
      board_done  <= 1'b0;
      error       <= 1'b0;
      busy        <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_hi        <= w_hi_nxt;
      r_n_tmp     <= w_n_tmp_nxt;
      n           <= w_n_nxt;
      m           <= w_m_nxt;
      r_line      <= w_line_nxt;
      r_kleft     <= w_kleft_nxt;
      r_acc       <= w_acc_nxt;
      r_first     <= w_first_nxt;
      r_addr      <= w_addr_nxt;
      write_ready <= w_wr;
      board_done  <= w_done;
      error       <= w_err_nxt;
      busy        <= w_busy_nxt;
      if (w_wr) begin
        write_index <= w_wr_idx;
        assignment  <= w_wr_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_clue_stream_parser.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_clue_stream_parser: directed self-checking bench for clue_stream_parser.  |
// | Rev 1.0 - initial release                                                   |
// +----------------------------------------------------------------------------+
module tb_clue_stream_parser;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  byte_in = 8'h00;
  logic        valid_in = 1'b0;
  logic        write_ready;
  logic [11:0] write_index;
  logic [15:0] assignment;
  logic        board_done;
  logic        error;
  logic        busy;
  logic [15:0] n;
  logic [15:0] m;

  clue_stream_parser dut (
    .clk         (clk),
    .rst         (rst),
    .byte_in     (byte_in),
    .valid_in    (valid_in),
    .write_ready (write_ready),
    .write_index (write_index),
    .assignment  (assignment),
    .board_done  (board_done),
    .error       (error),
    .busy        (busy),
    .n           (n),
    .m           (m)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_mis = 0;
  logic [31:0] cap_q[$];
  int          done_cnt = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  stim_q[$];
  int          cap_mark = 0;
  int          done_mark = 0;

  // Entry layout: {3'b0, board_done, write_index[11:0], assignment[15:0]}.
  always @(negedge clk) begin
    if (write_ready) cap_q.push_back({3'b000, board_done, write_index, assignment});
    if (board_done) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic e(input bit d, input int a, input int w);
    logic [31:0] a_v, w_v;
    a_v = a;
    w_v = w;
    exp_q.push_back({3'b000, d, a_v[11:0], w_v[15:0]});
  endtask

  task automatic s(input int b);
    logic [31:0] b_v;
    b_v = b;
    stim_q.push_back(b_v[7:0]);
  endtask

  task automatic push_2x2();
    s('h00); s('h02); s('h00); s('h02);
    s('h01); s('h02); s('h01); s('h01);
    s('h01); s('h02); s('h01); s('h01);
  endtask

  task automatic exp_2x2();
    e(0, 0, 'h8000); e(0, 1, 'h0002); e(0, 2, 'h8001); e(0, 3, 'h0001);
    e(0, 4, 'h8002); e(0, 5, 'h0002); e(0, 6, 'h8003); e(1, 7, 'h0001);
  endtask

  // Called at a negedge; gapmode 1 inserts idle cycles on odd bytes.
  task automatic send_all(input int gapmode);
    foreach (stim_q[i]) begin
      byte_in  = stim_q[i];
      valid_in = 1'b1;
      @(negedge clk);
      valid_in = 1'b0;
      byte_in  = 8'hA5;
      if (gapmode == 1) repeat (i % 2) @(negedge clk);
    end
    stim_q.delete();
  endtask

  task automatic run_check(input string tag);
    int got_n, exp_done;
    logic [31:0] got;
    repeat (4) @(negedge clk);
    got_n = cap_q.size() - cap_mark;
    check($sformatf("%s_nwr", tag), got_n, exp_q.size());
    exp_done = 0;
    foreach (exp_q[i]) begin
      got = (cap_mark + i < cap_q.size()) ? cap_q[cap_mark + i] : 32'hDEADBEEF;
      check($sformatf("%s_w%0d", tag, i), got, exp_q[i]);
      if (exp_q[i][28]) exp_done++;
    end
    check($sformatf("%s_ndone", tag), done_cnt - done_mark, exp_done);
    cap_mark  = cap_q.size();
    done_mark = done_cnt;
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    do_reset();
    check("rst_wr", write_ready, 0);
    check("rst_done", board_done, 0);
    check("rst_err", error, 0);
    check("rst_busy", busy, 0);
    check("rst_nm", {n, m}, 0);
    check("rst_data", {write_index, assignment}, 0);

    // Basic 2x2 board
    push_2x2(); send_all(0);
    exp_2x2(); run_check("b2x2");
    check("b2x2_nm", {n, m}, {16'd2, 16'd2});
    check("b2x2_err", error, 0);
    check("b2x2_busy", busy, 0);

    // Zero-clue 1x1 board, no reset: address must reload to base
    s('h00); s('h01); s('h00); s('h01); s('h00); s('h00); send_all(0);
    e(0, 0, 'h8000); e(1, 1, 'h8001); run_check("zero");
    check("zero_nm", {n, m}, {16'd1, 16'd1});

    // Infeasible row: second clue pushes acc to 5 > 3
    s('h00); s('h01); s('h00); s('h03); s('h02); send_all(0);
    check("inf_busy", busy, 1);
    check("inf_err0", error, 0);
    s('h02); s('h02); s('h01); s('h05); s('h00); s('h02); send_all(0);
    e(0, 0, 'h8000); e(0, 1, 'h0002); run_check("inf");
    check("inf_err", error, 1);
    check("inf_busyx", busy, 0);
    check("inf_nm", {n, m}, {16'd1, 16'd3});

    // N = 0 header fault
    do_reset();
    s('h00); s('h00); s('h00); send_all(0);
    check("n0_err3", error, 0);
    s('h02); s('h01); s('h02); send_all(0);
    run_check("n0");
    check("n0_err", error, 1);
    check("n0_nm", {n, m}, 0);

    // M = MAX_DIM+1 header fault
    do_reset();
    s('h00); s('h01); s('h00); s('h41); s('h00); send_all(0);
    run_check("m65");
    check("m65_err", error, 1);

    // K = MAX_CLUES+1
    do_reset();
    s('h00); s('h01); s('h00); s('h01); s('h21); s('h01); send_all(0);
    run_check("k33");
    check("k33_err", error, 1);

    // K = MAX_CLUES on a 1x63 board; 32 ones fill the row exactly (63)
    do_reset();
    s('h00); s('h01); s('h00); s('h3F); s('h20);
    for (int i = 0; i < 32; i++) s('h01);
    for (int j = 0; j < 63; j++) s('h00);
    send_all(0);
    e(0, 0, 'h8000);
    for (int i = 0; i < 32; i++) e(0, 1 + i, 'h0001);
    for (int j = 0; j < 63; j++) e(j == 62, 33 + j, 'h8001 + j);
    run_check("k32");
    check("k32_err", error, 0);

    // Reset in the middle of a board, then the full board again
    do_reset();
    s('h00); s('h02); s('h00); s('h02); s('h01); s('h02); send_all(0);
    e(0, 0, 'h8000); e(0, 1, 'h0002); run_check("part");
    do_reset();
    push_2x2(); send_all(0);
    exp_2x2(); run_check("restart");
    check("restart_err", error, 0);

    // Back-to-back boards with gaps and idle cycles
    push_2x2(); send_all(1);
    repeat (5) @(negedge clk);
    s('h00); s('h01); s('h00); s('h01); s('h00); s('h00); send_all(1);
    exp_2x2(); e(0, 0, 'h8000); e(1, 1, 'h8001); run_check("b2b");
    check("b2b_nm", {n, m}, {16'd1, 16'd1});
    check("b2b_err", error, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
